// File: rtl/pkt_ingress_arbiter_pkg.sv
// Shared definitions for the ingress arbiter: state encoding, default stream widths
// and the debug view of the arbitration FSM.
package pkt_ingress_arbiter_pkg;

    localparam int DEF_DATA_WIDTH  = 256;
    localparam int DEF_TUSER_WIDTH = 128;
    localparam int MAX_PORT_BITS   = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // rr_ptr is zero-extended to the widest supported port index.
    typedef struct packed {
        arb_state_e                 state;
        logic [MAX_PORT_BITS-1:0]   rr_ptr;
    } arb_dbg_t;

endpackage

// File: rtl/pkt_ingress_arbiter_if.sv
// AXI-Stream bundle between the ingress ports and the merged output stream.
// Handshake: a beat moves on a channel in a cycle where tvalid and tready are both high;
// once tvalid is raised, data/keep/user/last stay stable until that beat moves.
interface pkt_ingress_arbiter_if #(
    parameter int DW = 256,
    parameter int UW = 128,
    parameter int NP = 4
);
    logic [NP*DW-1:0]     s_axis_tdata;
    logic [NP*DW/8-1:0]   s_axis_tkeep;
    logic [NP*UW-1:0]     s_axis_tuser;
    logic [NP-1:0]        s_axis_tvalid;
    logic [NP-1:0]        s_axis_tlast;
    logic [NP-1:0]        s_axis_tready;

    logic [DW-1:0]        m_axis_tdata;
    logic [DW/8-1:0]      m_axis_tkeep;
    logic [UW-1:0]        m_axis_tuser;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;

    // Upstream sources plus the downstream sink.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

    // The arbiter itself.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

endinterface

// File: rtl/pkt_ingress_arbiter_rr_pick.sv
// Combinational round-robin selector: first requesting port scanning ptr, ptr+1, ...
// modulo NUM_PORTS.
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_BITS-1:0] ptr,
    output logic [PORT_BITS-1:0] gnt_idx,
    output logic                 gnt_vld
);

    int idx;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (!gnt_vld && req[idx[PORT_BITS-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[PORT_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/pkt_ingress_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream ingress ports into one
// registered output stream; grants are locked from first beat to tlast.
module pkt_ingress_arbiter
    import pkt_ingress_arbiter_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int NUM_PORTS            = 4,
    parameter int PORT_BITS            = 2
) (
    input  logic                  clk,
    input  logic                  aresetn,
    pkt_ingress_arbiter_if.slave  axis,
    input  logic                  arb_pause,
    output logic                  arb_idle,
    output logic [PORT_BITS-1:0]  cur_grant,
    output arb_dbg_t              dbg_o
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    arb_state_e             state_q, state_d;
    logic [PORT_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PORT_BITS-1:0]   grant_q, grant_d;
    logic [DW-1:0]          tdata_q;
    logic [KW-1:0]          tkeep_q;
    logic [UW-1:0]          tuser_q;
    logic                   tvalid_q, tlast_q;

    logic                   out_free, accept;
    logic [NUM_PORTS-1:0]   ready;
    logic [PORT_BITS-1:0]   pick_idx;
    logic                   pick_vld;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_rr_pick (
        .req     (axis.s_axis_tvalid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign out_free = ~tvalid_q | axis.m_axis_tready;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        ready    = '0;
        accept   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // Pause only blocks new grants; the pointer does not move while paused.
                if (!arb_pause && pick_vld) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == PORT_BITS'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                ready[grant_q] = out_free;
                accept         = out_free & axis.s_axis_tvalid[grant_q];
                if (accept && axis.s_axis_tlast[grant_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            if (accept) begin
                tvalid_q <= 1'b1;
                tlast_q  <= axis.s_axis_tlast[grant_q];
                tdata_q  <= axis.s_axis_tdata[grant_q*DW +: DW];
                tkeep_q  <= axis.s_axis_tkeep[grant_q*KW +: KW];
                tuser_q  <= axis.s_axis_tuser[grant_q*UW +: UW];
            end else if (axis.m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign axis.s_axis_tready = ready;
    assign axis.m_axis_tdata  = tdata_q;
    assign axis.m_axis_tkeep  = tkeep_q;
    assign axis.m_axis_tuser  = tuser_q;
    assign axis.m_axis_tvalid = tvalid_q;
    assign axis.m_axis_tlast  = tlast_q;

    assign arb_idle     = (state_q == ARB_IDLE) & ~tvalid_q;
    assign cur_grant    = grant_q;
    assign dbg_o.state  = state_q;
    assign dbg_o.rr_ptr = MAX_PORT_BITS'(rr_ptr_q);

endmodule

// File: tb/tb_pkt_ingress_arbiter.sv
// Directed bench for pkt_ingress_arbiter: per-port beat sources, an output recorder,
// and one task per scenario comparing recorded beats against hand-ordered expectations.
module tb_pkt_ingress_arbiter;
    import pkt_ingress_arbiter_pkg::*;

    localparam int W  = 256;
    localparam int UW = 128;
    localparam int NP = 4;
    localparam int PB = 2;
    localparam int KW = W / 8;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic           arb_pause = 1'b0;
    logic           arb_idle;
    logic [PB-1:0]  cur_grant;
    arb_dbg_t       dbg;

    pkt_ingress_arbiter_if #(.DW(W), .UW(UW), .NP(NP)) bus ();

    pkt_ingress_arbiter #(
        .C_S_AXIS_DATA_WIDTH  (W),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .NUM_PORTS            (NP),
        .PORT_BITS            (PB)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .axis      (bus),
        .arb_pause (arb_pause),
        .arb_idle  (arb_idle),
        .cur_grant (cur_grant),
        .dbg_o     (dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0]  data;
        logic          last;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        int            cyc;
    } obs_t;

    typedef struct {
        logic [NP-1:0] srdy;
        logic          mv;
        logic          mr;
        logic [W-1:0]  data;
        arb_state_e    st;
    } log_t;

    obs_t       obs_q[$];
    log_t       log_q[$];
    logic [W:0] exp_q[$];
    logic [W:0] src_q[NP][$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic logic [KW-1:0] keep_of(input logic [W-1:0] d);
        return d[KW-1:0];
    endfunction

    function automatic logic [UW-1:0] user_of(input logic [W-1:0] d);
        return ~d[UW-1:0];
    endfunction

    function automatic bit srcs_empty();
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Driver: present the head beat of each port's source queue.
    task automatic drive();
        logic [W:0] b;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                b = src_q[p][0];
                bus.s_axis_tvalid[p]          = 1'b1;
                bus.s_axis_tlast[p]           = b[W];
                bus.s_axis_tdata[p*W +: W]    = b[W-1:0];
                bus.s_axis_tkeep[p*KW +: KW]  = keep_of(b[W-1:0]);
                bus.s_axis_tuser[p*UW +: UW]  = user_of(b[W-1:0]);
            end else begin
                bus.s_axis_tvalid[p]          = 1'b0;
                bus.s_axis_tlast[p]           = 1'b0;
                bus.s_axis_tdata[p*W +: W]    = '0;
                bus.s_axis_tkeep[p*KW +: KW]  = '0;
                bus.s_axis_tuser[p*UW +: UW]  = '0;
            end
        end
    endtask

    task automatic add(input int p, input logic [31:0] d, input logic last);
        src_q[p].push_back({last, W'(d)});
        exp_q.push_back({last, W'(d)});
    endtask

    task automatic clear_rec();
        obs_q.delete();
        log_q.delete();
        exp_q.delete();
    endtask

    // One clock: sample at negedge, advance sources after the posedge.
    task automatic step();
        logic [NP-1:0] acc;
        obs_t o;
        log_t l;
        @(negedge clk);
        acc    = bus.s_axis_tvalid & bus.s_axis_tready;
        l.srdy = bus.s_axis_tready;
        l.mv   = bus.m_axis_tvalid;
        l.mr   = bus.m_axis_tready;
        l.data = bus.m_axis_tdata;
        l.st   = dbg.state;
        log_q.push_back(l);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            o.data = bus.m_axis_tdata;
            o.last = bus.m_axis_tlast;
            o.keep = bus.m_axis_tkeep;
            o.user = bus.m_axis_tuser;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        drive();
    endtask

    task automatic drain(input int max, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max; i++) begin
            step();
            if (srcs_empty() && arb_idle) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bus.m_axis_tready = 1'b0;
        drive();
        bus.s_axis_tvalid[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tuser} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h, want all zero", bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata);
        end
        n_vec++;
        if (bus.s_axis_tready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_tready: got %b want 0000", bus.s_axis_tready);
        end
        n_vec++;
        if ({arb_idle, cur_grant} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_idle_grant: got idle=%b grant=%0d want idle=1 grant=0", arb_idle, cur_grant);
        end
        n_vec++;
        if (dbg !== '{state: ARB_IDLE, rr_ptr: 3'd0}) begin
            n_err++;
            $display("FAIL reset_state: got state=%0d rr=%0d want state=0 rr=0", dbg.state, dbg.rr_ptr);
        end
        bus.s_axis_tvalid = '0;
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_single_port();
        bit to;
        int c0;
        logic [W:0] e;
        clear_rec();
        bus.m_axis_tready = 1'b1;
        add(0, 32'hA0, 1'b0);
        add(0, 32'hA1, 1'b0);
        add(0, 32'hA2, 1'b1);
        drive();
        c0 = cyc;
        drain(30, to);
        n_vec++;
        if (to) begin n_err++; $display("FAIL single_port_timeout: got timeout, want drained"); end
        n_vec++;
        if (log_q[0].srdy !== 4'b0000 || log_q[1].srdy !== 4'b0001) begin
            n_err++;
            $display("FAIL single_port_tready: got %b,%b want 0000,0001", log_q[0].srdy, log_q[1].srdy);
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL single_port_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            e = exp_q[i];
            n_vec++;
            if ({obs_q[i].last, obs_q[i].data, obs_q[i].keep, obs_q[i].user} !== {e[W], e[W-1:0], keep_of(e[W-1:0]), user_of(e[W-1:0])}) begin
                n_err++;
                $display("FAIL single_port_beat%0d: got last=%b data=%h want last=%b data=%h", i, obs_q[i].last, obs_q[i].data, e[W], e[W-1:0]);
            end
            n_vec++;
            if (obs_q[i].cyc - c0 != i + 2) begin
                n_err++;
                $display("FAIL single_port_latency%0d: got cycle %0d want %0d", i, obs_q[i].cyc - c0, i + 2);
            end
        end
        n_vec++;
        if (dbg.rr_ptr !== 3'd1 || cur_grant !== 2'd0) begin
            n_err++;
            $display("FAIL single_port_rr: got rr=%0d grant=%0d want rr=1 grant=0", dbg.rr_ptr, cur_grant);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit to;
        logic [W:0] e;
        clear_rec();
        bus.m_axis_tready = 1'b1;
        for (int b = 0; b < 4; b++) src_q[0].push_back({b == 3, W'(32'hB0 + b)});
        drive();
        repeat (3) step();
        n_vec++;
        if (dbg.state !== ARB_LOCK || bus.m_axis_tvalid !== 1'b1 || dbg.rr_ptr !== 3'd1) begin
            n_err++;
            $display("FAIL midpkt_pre: got state=%0d valid=%b rr=%0d want state=1 valid=1 rr=1", dbg.state, bus.m_axis_tvalid, dbg.rr_ptr);
        end
        #3;
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata} !== '0 || bus.s_axis_tready !== 4'b0000) begin
            n_err++;
            $display("FAIL midpkt_async: got valid=%b data=%h tready=%b want 0/0/0000", bus.m_axis_tvalid, bus.m_axis_tdata, bus.s_axis_tready);
        end
        n_vec++;
        if (arb_idle !== 1'b1 || dbg !== '{state: ARB_IDLE, rr_ptr: 3'd0}) begin
            n_err++;
            $display("FAIL midpkt_state: got idle=%b state=%0d rr=%0d want idle=1 state=0 rr=0", arb_idle, dbg.state, dbg.rr_ptr);
        end
        src_q[0].delete();
        drive();
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        clear_rec();
        add(0, 32'hC0, 1'b1);
        add(3, 32'hD0, 1'b1);
        drive();
        drain(30, to);
        n_vec++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL midpkt_restart_count: got %0d beats timeout=%b want %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            e = exp_q[i];
            n_vec++;
            if ({obs_q[i].last, obs_q[i].data} !== e) begin
                n_err++;
                $display("FAIL midpkt_restart_beat%0d: got last=%b data=%h want last=%b data=%h", i, obs_q[i].last, obs_q[i].data, e[W], e[W-1:0]);
            end
        end
    endtask

    task automatic test_all_ports();
        bit to;
        logic [W:0] e;
        int gap;
        clear_rec();
        bus.m_axis_tready = 1'b1;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 2; b++) add(p, 32'h100 + 32'(p * 16 + b), b == 1);
        drive();
        drain(60, to);
        n_vec++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL all_ports_count: got %0d beats timeout=%b want %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            e = exp_q[i];
            n_vec++;
            if ({obs_q[i].last, obs_q[i].data, obs_q[i].keep, obs_q[i].user} !== {e[W], e[W-1:0], keep_of(e[W-1:0]), user_of(e[W-1:0])}) begin
                n_err++;
                $display("FAIL all_ports_beat%0d: got last=%b data=%h want last=%b data=%h", i, obs_q[i].last, obs_q[i].data, e[W], e[W-1:0]);
            end
            if (i > 0) begin
                gap = (i % 2 == 0) ? 2 : 1;
                n_vec++;
                if (obs_q[i].cyc - obs_q[i-1].cyc != gap) begin
                    n_err++;
                    $display("FAIL all_ports_gap%0d: got %0d cycles want %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, gap);
                end
            end
        end
        n_vec++;
        if (dbg.rr_ptr !== 3'd0 || cur_grant !== 2'd3) begin
            n_err++;
            $display("FAIL all_ports_rr: got rr=%0d grant=%0d want rr=0 grant=3", dbg.rr_ptr, cur_grant);
        end
    endtask

    task automatic test_single_beat();
        bit to;
        logic [W:0] e;
        clear_rec();
        bus.m_axis_tready = 1'b1;
        add(0, 32'hE0, 1'b1);
        add(1, 32'hE1, 1'b1);
        drive();
        drain(30, to);
        n_vec++;
        if (to || obs_q.size() != 2) begin
            n_err++;
            $display("FAIL single_beat_count: got %0d beats timeout=%b want 2", obs_q.size(), to);
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            e = exp_q[i];
            n_vec++;
            if ({obs_q[i].last, obs_q[i].data} !== e) begin
                n_err++;
                $display("FAIL single_beat_beat%0d: got last=%b data=%h want last=%b data=%h", i, obs_q[i].last, obs_q[i].data, e[W], e[W-1:0]);
            end
        end
        if (obs_q.size() == 2) begin
            n_vec++;
            if (obs_q[1].cyc - obs_q[0].cyc != 2) begin
                n_err++;
                $display("FAIL single_beat_gap: got %0d cycles want 2", obs_q[1].cyc - obs_q[0].cyc);
            end
        end
        n_vec++;
        if (dbg.rr_ptr !== 3'd2) begin
            n_err++;
            $display("FAIL single_beat_rr: got rr=%0d want 2", dbg.rr_ptr);
        end
    endtask

    task automatic test_stall();
        bit to;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W:0] e;
        logic [NP-1:0] want_rdy;
        clear_rec();
        for (int b = 0; b < 4; b++) add(1, 32'hF0 + 32'(b), b == 3);
        drive();
        to = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bus.m_axis_tready = pat[k % 4];
            step();
            if (srcs_empty() && arb_idle) begin
                to = 1'b0;
                break;
            end
        end
        bus.m_axis_tready = 1'b1;
        n_vec++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL stall_count: got %0d beats timeout=%b want %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            e = exp_q[i];
            n_vec++;
            if ({obs_q[i].last, obs_q[i].data} !== e) begin
                n_err++;
                $display("FAIL stall_beat%0d: got last=%b data=%h want last=%b data=%h", i, obs_q[i].last, obs_q[i].data, e[W], e[W-1:0]);
            end
        end
        foreach (log_q[i]) begin
            want_rdy = (log_q[i].st == ARB_LOCK && (!log_q[i].mv || log_q[i].mr)) ? 4'b0010 : 4'b0000;
            n_vec++;
            if (log_q[i].srdy !== want_rdy) begin
                n_err++;
                $display("FAIL stall_tready%0d: got %b want %b", i, log_q[i].srdy, want_rdy);
            end
            if (i + 1 < log_q.size() && log_q[i].mv && !log_q[i].mr) begin
                n_vec++;
                if (!log_q[i+1].mv || log_q[i+1].data !== log_q[i].data) begin
                    n_err++;
                    $display("FAIL stall_hold%0d: got valid=%b data=%h want valid=1 data=%h", i, log_q[i+1].mv, log_q[i+1].data, log_q[i].data);
                end
            end
        end
    endtask

    task automatic test_pause();
        bit to;
        logic [W:0] e;
        clear_rec();
        bus.m_axis_tready = 1'b1;
        add(2, 32'h20, 1'b0);
        add(2, 32'h21, 1'b0);
        add(2, 32'h22, 1'b1);
        drive();
        repeat (2) step();
        arb_pause = 1'b1;
        src_q[0].push_back({1'b1, W'(32'h30)});
        src_q[3].push_back({1'b1, W'(32'h40)});
        drive();
        log_q.delete();
        repeat (8) step();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL pause_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            e = exp_q[i];
            n_vec++;
            if ({obs_q[i].last, obs_q[i].data} !== e) begin
                n_err++;
                $display("FAIL pause_beat%0d: got last=%b data=%h want last=%b data=%h", i, obs_q[i].last, obs_q[i].data, e[W], e[W-1:0]);
            end
        end
        n_vec++;
        if (arb_idle !== 1'b1 || bus.s_axis_tready !== 4'b0000 || bus.s_axis_tvalid !== 4'b1001) begin
            n_err++;
            $display("FAIL pause_hold: got idle=%b tready=%b tvalid=%b want 1/0000/1001", arb_idle, bus.s_axis_tready, bus.s_axis_tvalid);
        end
        n_vec++;
        if (dbg !== '{state: ARB_IDLE, rr_ptr: 3'd3} || log_q[7].srdy !== 4'b0000) begin
            n_err++;
            $display("FAIL pause_state: got state=%0d rr=%0d want state=0 rr=3", dbg.state, dbg.rr_ptr);
        end
        clear_rec();
        arb_pause = 1'b0;
        exp_q.push_back({1'b1, W'(32'h40)});
        exp_q.push_back({1'b1, W'(32'h30)});
        step();
        n_vec++;
        if (cur_grant !== 2'd3 || dbg.state !== ARB_LOCK) begin
            n_err++;
            $display("FAIL pause_release_grant: got grant=%0d state=%0d want grant=3 state=1", cur_grant, dbg.state);
        end
        drain(30, to);
        n_vec++;
        if (to || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL pause_release_count: got %0d beats timeout=%b want %0d", obs_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            e = exp_q[i];
            n_vec++;
            if ({obs_q[i].last, obs_q[i].data} !== e) begin
                n_err++;
                $display("FAIL pause_release_beat%0d: got last=%b data=%h want last=%b data=%h", i, obs_q[i].last, obs_q[i].data, e[W], e[W-1:0]);
            end
        end
    endtask

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tuser  = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
        test_reset();
        test_single_port();
        test_reset_mid_packet();
        test_all_ports();
        test_single_beat();
        test_stall();
        test_pause();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_ingress_arbiter.md
Name: pkt_ingress_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream ingress ports onto the single stream feeding the packet filter at the head of the RMT pipeline.
- A grant is locked from the first beat of a packet until its tlast beat, so packets never interleave.
- A pause input lets the control/reconfiguration logic stop new grants at packet boundaries while tables are rewritten; in-flight packets always complete.
- Output goes through one registered stage with full ready/valid backpressure.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width per port.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width per port; passed through unmodified.
- NUM_PORTS, 4, number of ingress ports (2..8).
- PORT_BITS, 2, clog2(NUM_PORTS); width of the grant index.

Ports:
- clk  in  1  single clock for the whole block.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  port i occupies slice [i*W +: W].
- s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  flattened per port, same slicing.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  flattened per port, same slicing.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready; at most one bit high.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  merged stream data (registered).
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  merged keep.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  merged user.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged last.
- m_axis_tready  in  1  downstream ready.
- arb_pause  in  1  1 = grant no new packet.
- arb_idle  out  1  1 = no packet locked and output register empty; used by the config logic as a safe-to-reconfigure flag.
- cur_grant  out  PORT_BITS  index of the locked or last-granted port (debug).

Behaviour:
- Reset (aresetn=0, asynchronous) forces the following; reset mid-packet abandons the packet, and upstream must resend.
  - m_axis_tvalid/tlast/tdata/tkeep/tuser = 0.
  - state = ARB_IDLE, rr_ptr = 0, cur_grant = 0.
  - s_axis_tready = 0, arb_idle = 1.
- out_free = ~m_axis_tvalid | m_axis_tready.
- State ARB_IDLE:
  - all s_axis_tready = 0.
  - If arb_pause = 0 and any s_axis_tvalid is set, select the first valid port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - On selection, register cur_grant = selected port, set rr_ptr = (selected + 1) mod NUM_PORTS, and move to ARB_LOCK next cycle.
  - If arb_pause = 1, stay in ARB_IDLE and leave rr_ptr unchanged.
- State ARB_LOCK:
  - s_axis_tready[cur_grant] = out_free; all other ready bits = 0.
  - A beat is accepted when s_axis_tvalid[cur_grant] & s_axis_tready[cur_grant]. The beat loads the output register next cycle with m_axis_tvalid = 1, so latency is 1 cycle from acceptance to output.
  - If m_axis_tready = 1 and no beat is accepted, clear m_axis_tvalid. Otherwise hold all m_axis_* stable (AXIS rule).
  - An accepted beat with tlast = 1 returns the FSM to ARB_IDLE.
  - arb_pause is ignored in ARB_LOCK; pausing takes effect only at packet boundaries.
- Throughput: one idle cycle between packets (the arbitration cycle); full rate within a packet.
- A granted port that drops tvalid mid-packet keeps the lock; the arbiter waits indefinitely, with no timeout.
- Single-beat packets (tvalid and tlast on the same beat) are legal: lock for one beat, then return to ARB_IDLE.
- If a valid asserts during ARB_LOCK on a non-granted port, it waits; no starvation, since the port is served within NUM_PORTS grants.
- arb_idle = (state == ARB_IDLE) & ~m_axis_tvalid (combinational).
- tuser and tkeep are passed bit-exact from the granted port.

Decomposition:
- Shared package / header: state encodings ARB_IDLE = 0 and ARB_LOCK = 1, plus the default widths 256/128, shared with the packet filter.
- Sub-module rr_pick: combinational round-robin selector with inputs req[NUM_PORTS] and ptr[PORT_BITS] and outputs gnt_idx and gnt_vld. Instantiated once; verified standalone.

Test Plan:
- Port 0 alone sends a 3-beat packet (tdata = 0xA0..A2), m_axis_tready = 1. Expect s_axis_tready[0] high from cycle 2, output beats on cycles 3..5 with tlast on the third, and rr_ptr = 1 afterwards.
- All 4 ports hold a 2-beat packet at once. Expect output port order 0, 1, 2, 3, with no beat interleaving and one idle cycle between packets.
- Port 1 is locked and m_axis_tready is toggled 1, 0, 0, 1. Expect s_axis_tready[1] to track out_free, m_axis_tdata stable while stalled, and no beat lost or duplicated.
- arb_pause raised mid-packet on port 2. Expect the packet to finish (tlast emitted), then no new grant and arb_idle = 1 while ports 0 and 3 are valid. When pause drops, port 3 is granted (rr_ptr = 3).
- Single-beat packets back-to-back on ports 0 and 1. Expect each to appear with tvalid = tlast = 1, separated by one idle cycle.
- aresetn pulsed low mid-packet on port 0. Expect all outputs 0 immediately (asynchronous), and after release the next grant restarts from rr_ptr = 0.
